id_scoreboard: RTL and testbench

Register scoreboard and issue controller for the decode stage. It tracks integer and floating-point destination registers owned by in-flight multi-cycle operations (loads, FP divide/sqrt) and holds decode while any source or destination is still pending. Busy state is cleared from the write-back port that also drives both register files. It sits beside the decode stage and drives the decode/fetch stall.

---
 rtl/id_scoreboard.sv | 106 ++++++++++
 tb/tb_id_scoreboard.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard: tracks int/FP destinations owned by in-flight
// long-latency operations and stalls decode on RAW, WAW or capacity hazards.
module id_scoreboard #(
   parameter  int MAX_INFLIGHT = 4,
   parameter  int CNT_W        = 32,
   localparam int IF_W         = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             D_valid,
   input  logic             flush,
   input  logic [4:0]       D_rs1,
   input  logic [4:0]       D_rs2,
   input  logic [4:0]       D_rd,
   input  logic [4:0]       D_rs1_f,
   input  logic [4:0]       D_rs2_f,
   input  logic [4:0]       D_rd_f,
   input  logic             D_use_rs1,
   input  logic             D_use_rs2,
   input  logic             D_use_rs1_f,
   input  logic             D_use_rs2_f,
   input  logic             D_reg_write_enable,
   input  logic             D_reg_write_enable_f,
   input  logic             D_long,
   input  logic             W_write_enable,
   input  logic             W_write_enable_f,
   input  logic [4:0]       W_rd,
   output logic             D_stall,
   output logic             D_issue,
   output logic [IF_W-1:0]  inflight,
   output logic             full,
   output logic [CNT_W-1:0] stall_count
);

   logic [31:0]     busy_i;
   logic [31:0]     busy_f;
   logic [31:0]     busy_i_nxt;
   logic [31:0]     busy_f_nxt;
   logic [IF_W-1:0] inflight_nxt;
   logic            live;
   logic            raw;
   logic            waw;
   logic            cap;
   logic            hazard;
   logic            set_i;
   logic            set_f;
   logic            clr_i;
   logic            clr_f;

   // Reset blocks decode outright so nothing issues against a scoreboard being cleared.
   assign live = D_valid & ~flush & ~rst;

   assign raw = (D_use_rs1   & busy_i[D_rs1])
              | (D_use_rs2   & busy_i[D_rs2])
              | (D_use_rs1_f & busy_f[D_rs1_f])
              | (D_use_rs2_f & busy_f[D_rs2_f]);

   assign waw = (D_reg_write_enable   & busy_i[D_rd])
              | (D_reg_write_enable_f & busy_f[D_rd_f]);

   assign cap    = D_long & (D_reg_write_enable | D_reg_write_enable_f) & full;
   assign hazard = raw | waw | cap;

   assign D_stall = live & hazard;
   assign D_issue = live & ~hazard;

   assign set_i = D_issue & D_long & D_reg_write_enable & (D_rd != 5'd0);
   assign set_f = D_issue & D_long & D_reg_write_enable_f;
   assign clr_i = W_write_enable   & busy_i[W_rd];
   assign clr_f = W_write_enable_f & busy_f[W_rd];

   always_comb begin
      // NOTE: defaults first so every path assigns every bit; otherwise a latch is inferred.
      busy_i_nxt = busy_i;
      busy_f_nxt = busy_f;
      if (clr_i) busy_i_nxt[W_rd]   = 1'b0;
      if (clr_f) busy_f_nxt[W_rd]   = 1'b0;
      if (set_i) busy_i_nxt[D_rd]   = 1'b1;
      if (set_f) busy_f_nxt[D_rd_f] = 1'b1;
      busy_i_nxt[0] = 1'b0;
   end

   // Every busy bit is exactly one outstanding write, so the count tracks sets minus clears.
   assign inflight_nxt = inflight + IF_W'(set_i) + IF_W'(set_f)
                       - IF_W'(clr_i) - IF_W'(clr_f);

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (rst) begin
         // NOTE: busy vectors are reset too; stale ownership would stall decode forever.
         busy_i      <= '0;
         busy_f      <= '0;
         inflight    <= '0;
         full        <= 1'b0;
         stall_count <= '0;
      end else begin
         busy_i   <= busy_i_nxt;
         busy_f   <= busy_f_nxt;
         inflight <= inflight_nxt;
         full     <= (inflight_nxt == IF_W'(MAX_INFLIGHT));
         if (D_stall && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: hazard table, directed corner sequences,
// and randomized traffic against a set-of-owned-registers reference model.
module tb_id_scoreboard;

   localparam int MAX = 4;
   localparam int CW  = 6;
   localparam int IFW = $clog2(MAX + 1);
   localparam int NV  = 15;

   localparam logic [6:0] U1  = 7'b1000000;
   localparam logic [6:0] U2  = 7'b0100000;
   localparam logic [6:0] U1F = 7'b0010000;
   localparam logic [6:0] U2F = 7'b0001000;
   localparam logic [6:0] WE  = 7'b0000100;
   localparam logic [6:0] WEF = 7'b0000010;
   localparam logic [6:0] LNG = 7'b0000001;

   logic           clk = 1'b0;
   logic           rst;
   logic           D_valid, flush;
   logic [4:0]     D_rs1, D_rs2, D_rd, D_rs1_f, D_rs2_f, D_rd_f;
   logic           D_use_rs1, D_use_rs2, D_use_rs1_f, D_use_rs2_f;
   logic           D_reg_write_enable, D_reg_write_enable_f, D_long;
   logic           W_write_enable, W_write_enable_f;
   logic [4:0]     W_rd;
   logic           D_stall, D_issue;
   logic [IFW-1:0] inflight;
   logic           full;
   logic [CW-1:0]  stall_count;

   int n_tests  = 0;
   int n_failed = 0;

   typedef struct {
      logic       valid;
      logic       flush;
      logic [4:0] rs1, rs2, rd, rs1f, rs2f, rdf;
      logic [6:0] fl;
      logic       exp_stall;
      logic       exp_issue;
   } vec_t;

   vec_t tbl[NV];

   // Reference model: the set of registers currently owned by long operations.
   bit [31:0] m_busy_i;
   bit [31:0] m_busy_f;
   int        m_stalls;

   id_scoreboard #(.MAX_INFLIGHT(MAX), .CNT_W(CW)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .D_valid             (D_valid),
      .flush               (flush),
      .D_rs1               (D_rs1),
      .D_rs2               (D_rs2),
      .D_rd                (D_rd),
      .D_rs1_f             (D_rs1_f),
      .D_rs2_f             (D_rs2_f),
      .D_rd_f              (D_rd_f),
      .D_use_rs1           (D_use_rs1),
      .D_use_rs2           (D_use_rs2),
      .D_use_rs1_f         (D_use_rs1_f),
      .D_use_rs2_f         (D_use_rs2_f),
      .D_reg_write_enable  (D_reg_write_enable),
      .D_reg_write_enable_f(D_reg_write_enable_f),
      .D_long              (D_long),
      .W_write_enable      (W_write_enable),
      .W_write_enable_f    (W_write_enable_f),
      .W_rd                (W_rd),
      .D_stall             (D_stall),
      .D_issue             (D_issue),
      .inflight            (inflight),
      .full                (full),
      .stall_count         (stall_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_failed++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int m_inflight();
      int n = 0;
      for (int r = 0; r < 32; r++) n += int'(m_busy_i[r]) + int'(m_busy_f[r]);
      return n;
   endfunction

   task automatic model_comb(output logic s, output logic i);
      logic haz;
      haz = (D_use_rs1 && m_busy_i[D_rs1]) || (D_use_rs2 && m_busy_i[D_rs2])
         || (D_use_rs1_f && m_busy_f[D_rs1_f]) || (D_use_rs2_f && m_busy_f[D_rs2_f])
         || (D_reg_write_enable && m_busy_i[D_rd])
         || (D_reg_write_enable_f && m_busy_f[D_rd_f])
         || (D_long && (D_reg_write_enable || D_reg_write_enable_f) && m_inflight() == MAX);
      s = D_valid && !flush && !rst && haz;
      i = D_valid && !flush && !rst && !haz;
   endtask

   task automatic model_clock(input logic s, input logic i);
      bit ci, cf;
      if (rst) begin
         m_busy_i = '0;
         m_busy_f = '0;
         m_stalls = 0;
      end else begin
         ci = W_write_enable && m_busy_i[W_rd];
         cf = W_write_enable_f && m_busy_f[W_rd];
         if (ci) m_busy_i[W_rd] = 1'b0;
         if (cf) m_busy_f[W_rd] = 1'b0;
         if (i && D_long) begin
            if (D_reg_write_enable && D_rd != 5'd0) m_busy_i[D_rd] = 1'b1;
            if (D_reg_write_enable_f) m_busy_f[D_rd_f] = 1'b1;
         end
         if (s && m_stalls < (1 << CW) - 1) m_stalls++;
      end
   endtask

   // One clock: compare decode outputs, clock the DUT and the model, compare state outputs.
   task automatic step();
      logic es, ei;
      model_comb(es, ei);
      #1;
      check("D_stall", 32'(D_stall), 32'(es));
      check("D_issue", 32'(D_issue), 32'(ei));
      @(posedge clk);
      model_clock(es, ei);
      #1;
      check("inflight", 32'(inflight), 32'(m_inflight()));
      check("full", 32'(full), 32'(m_inflight() == MAX));
      check("stall_count", 32'(stall_count), 32'(m_stalls));
   endtask

   task automatic idle();
      D_valid = 1'b0; flush = 1'b0;
      D_rs1 = 5'd0; D_rs2 = 5'd0; D_rd = 5'd0;
      D_rs1_f = 5'd0; D_rs2_f = 5'd0; D_rd_f = 5'd0;
      {D_use_rs1, D_use_rs2, D_use_rs1_f, D_use_rs2_f,
       D_reg_write_enable, D_reg_write_enable_f, D_long} = 7'b0;
      W_write_enable = 1'b0; W_write_enable_f = 1'b0; W_rd = 5'd0;
   endtask

   task automatic inst(input logic [4:0] rs1, rs2, rd, rs1f, rs2f, rdf, input logic [6:0] fl);
      idle();
      D_valid = 1'b1;
      D_rs1 = rs1; D_rs2 = rs2; D_rd = rd;
      D_rs1_f = rs1f; D_rs2_f = rs2f; D_rd_f = rdf;
      {D_use_rs1, D_use_rs2, D_use_rs1_f, D_use_rs2_f,
       D_reg_write_enable, D_reg_write_enable_f, D_long} = fl;
   endtask

   task automatic wb(input logic wi, input logic wf, input logic [4:0] r);
      W_write_enable = wi; W_write_enable_f = wf; W_rd = r;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   function automatic vec_t mk(input logic [1:0] vf, input logic [4:0] rs1, rs2, rd,
                               input logic [4:0] rs1f, rs2f, rdf,
                               input logic [6:0] fl, input logic [1:0] ex);
      vec_t v;
      v.valid = vf[1]; v.flush = vf[0];
      v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
      v.rs1f = rs1f; v.rs2f = rs2f; v.rdf = rdf;
      v.fl = fl;
      v.exp_stall = ex[1]; v.exp_issue = ex[0];
      return v;
   endfunction

   initial begin
      // Hazard table, evaluated with x5 and f3 owned and two writes in flight.
      tbl[0]  = mk(2'b10, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, U1,       2'b10);
      tbl[1]  = mk(2'b10, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, U2,       2'b10);
      tbl[2]  = mk(2'b10, 5'd6, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, U1,       2'b01);
      tbl[3]  = mk(2'b10, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, U1F,      2'b10);
      tbl[4]  = mk(2'b10, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, U2F,      2'b10);
      tbl[5]  = mk(2'b10, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, U1,       2'b01);
      tbl[6]  = mk(2'b10, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, WE,       2'b10);
      tbl[7]  = mk(2'b10, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, WEF,      2'b10);
      tbl[8]  = mk(2'b10, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, WEF,      2'b01);
      tbl[9]  = mk(2'b11, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, U1,       2'b00);
      tbl[10] = mk(2'b00, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, U1,       2'b00);
      tbl[11] = mk(2'b10, 5'd3, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, U1 | U1F, 2'b01);
      tbl[12] = mk(2'b10, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, LNG,      2'b01);
      tbl[13] = mk(2'b10, 5'd5, 5'd6, 5'd0, 5'd0, 5'd0, 5'd0, U2,       2'b01);
      tbl[14] = mk(2'b10, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd0, WE | LNG, 2'b01);

      m_busy_i = '0; m_busy_f = '0; m_stalls = 0;
      do_reset();
      do_reset();
      check("reset_inflight", 32'(inflight), 32'd0);

      inst(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, WE | LNG);  step();
      inst(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, WEF | LNG); step();
      idle();
      for (int k = 0; k < NV; k++) begin
         @(negedge clk);
         D_valid = tbl[k].valid; flush = tbl[k].flush;
         D_rs1 = tbl[k].rs1; D_rs2 = tbl[k].rs2; D_rd = tbl[k].rd;
         D_rs1_f = tbl[k].rs1f; D_rs2_f = tbl[k].rs2f; D_rd_f = tbl[k].rdf;
         {D_use_rs1, D_use_rs2, D_use_rs1_f, D_use_rs2_f,
          D_reg_write_enable, D_reg_write_enable_f, D_long} = tbl[k].fl;
         #1;
         check($sformatf("vec%0d_stall", k), 32'(D_stall), 32'(tbl[k].exp_stall));
         check($sformatf("vec%0d_issue", k), 32'(D_issue), 32'(tbl[k].exp_issue));
         idle();
      end

      // Integer long op, dependent reader, write-back release.
      do_reset();
      inst(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, WE | LNG); step();
      check("a_inflight", 32'(inflight), 32'd1);
      inst(5'd5, 5'd0, 5'd10, 5'd0, 5'd0, 5'd0, U1 | WE);
      #1 check("a_stall", 32'(D_stall), 32'd1);
      step();
      wb(1'b1, 1'b0, 5'd5); step();
      wb(1'b0, 1'b0, 5'd0);
      #1 check("a_issue", 32'(D_issue), 32'd1);
      step();
      check("a_stall_count", 32'(stall_count), 32'd2);
      check("a_inflight0", 32'(inflight), 32'd0);

      // FP long op; FP reader stalls, integer reader of x3 does not.
      inst(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, WEF | LNG); step();
      inst(5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, U2F);
      #1 check("b_fp_stall", 32'(D_stall), 32'd1);
      step();
      inst(5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, U1);
      #1 check("b_int_issue", 32'(D_issue), 32'd1);
      step();
      inst(5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, U2F); wb(1'b0, 1'b1, 5'd3); step();
      wb(1'b0, 1'b0, 5'd0); step();

      // Capacity: four long writes fill the scoreboard.
      for (int r = 1; r <= 4; r++) begin
         inst(5'd0, 5'd0, 5'(r), 5'd0, 5'd0, 5'd0, WE | LNG); step();
      end
      check("c_full", 32'(full), 32'd1);
      check("c_inflight", 32'(inflight), 32'd4);
      inst(5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 5'd0, WE | LNG);
      #1 check("c_cap_stall", 32'(D_stall), 32'd1);
      step();
      inst(5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd0, WE);
      #1 check("c_short_issue", 32'(D_issue), 32'd1);
      step();
      inst(5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 5'd0, WE | LNG); wb(1'b1, 1'b0, 5'd2); step();
      check("c_full_drop", 32'(full), 32'd0);
      wb(1'b0, 1'b0, 5'd0);
      #1 check("c_fifth_issue", 32'(D_issue), 32'd1);
      step();
      idle(); wb(1'b1, 1'b0, 5'd1); step();
      wb(1'b1, 1'b0, 5'd3); step();
      wb(1'b1, 1'b0, 5'd4); step();
      wb(1'b1, 1'b0, 5'd6); step();
      check("c_drained", 32'(inflight), 32'd0);

      // Long op to x0 is never tracked.
      inst(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, WE | LNG); step();
      check("d_x0_inflight", 32'(inflight), 32'd0);
      inst(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, U1 | U2);
      #1 check("d_x0_reader", 32'(D_issue), 32'd1);
      step();

      // WAW: short write to a register owned by a long op.
      inst(5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 5'd0, WE | LNG); step();
      inst(5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 5'd0, WE);
      #1 check("e_waw_stall", 32'(D_stall), 32'd1);
      step();
      wb(1'b1, 1'b0, 5'd8); step();
      wb(1'b0, 1'b0, 5'd0); step();

      // Flush suppresses the hazard; reset discards three outstanding writes.
      inst(5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 5'd0, WE | LNG); step();
      inst(5'd9, 5'd0, 5'd9, 5'd0, 5'd0, 5'd0, U1 | WE | LNG); flush = 1'b1;
      #1 check("f_flush_stall", 32'(D_stall), 32'd0);
      check("f_flush_issue", 32'(D_issue), 32'd0);
      step();
      inst(5'd0, 5'd0, 5'd10, 5'd0, 5'd0, 5'd0, WE | LNG); step();
      inst(5'd0, 5'd0, 5'd11, 5'd0, 5'd0, 5'd0, WE | LNG); step();
      check("f_inflight3", 32'(inflight), 32'd3);
      inst(5'd9, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, U1); rst = 1'b1;
      #1 check("f_rst_stall", 32'(D_stall), 32'd0);
      step();
      rst = 1'b0;
      check("f_rst_inflight", 32'(inflight), 32'd0);
      check("f_rst_full", 32'(full), 32'd0);
      #1 check("f_after_rst_issue", 32'(D_issue), 32'd1);
      step();

      // Stall counter saturation.
      do_reset();
      inst(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, WE | LNG); step();
      inst(5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, U1);
      repeat (70) step();
      check("sat_stall_count", 32'(stall_count), 32'((1 << CW) - 1));
      do_reset();

      // Randomized traffic on a small register window to provoke hazards.
      for (int c = 0; c < 3000; c++) begin
         int kind;
         rst     = ($urandom_range(0, 199) == 0);
         D_valid = ($urandom_range(0, 9) < 8);
         flush   = ($urandom_range(0, 9) == 0);
         D_rs1   = 5'($urandom_range(0, 7));
         D_rs2   = 5'($urandom_range(0, 7));
         D_rd    = 5'($urandom_range(0, 7));
         D_rs1_f = 5'($urandom_range(0, 7));
         D_rs2_f = 5'($urandom_range(0, 7));
         D_rd_f  = 5'($urandom_range(0, 7));
         D_use_rs1   = 1'($urandom_range(0, 1));
         D_use_rs2   = 1'($urandom_range(0, 1));
         D_use_rs1_f = 1'($urandom_range(0, 1));
         D_use_rs2_f = 1'($urandom_range(0, 1));
         kind = $urandom_range(0, 2);
         D_reg_write_enable   = (kind == 0);
         D_reg_write_enable_f = (kind == 1);
         D_long = ($urandom_range(0, 9) < 4);
         W_write_enable   = ($urandom_range(0, 9) < 3);
         W_write_enable_f = ($urandom_range(0, 9) < 3);
         W_rd = 5'($urandom_range(0, 7));
         step();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule
